// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks a captured operand pair LSB first,
// producing sum = a + b + cin after WIDTH cycles behind a valid/ready handshake.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_bit, last_bit;

  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign s_bit    = fa_sum(a_sh[0], b_sh[0], carry);
  assign c_bit    = fa_carry(a_sh[0], b_sh[0], carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture in IDLE, shift one bit per edge in SHIFT; DONE leaves everything frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_bit;
          sum   <= {s_bit, sum[WIDTH-1:1]};
          if (last_bit) begin
            cout <= c_bit;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH = 4) with hand-computed expected sums.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int tests  = 0;
  int failed = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operand set at the next edge; in_valid is dropped unless hold is set.
  task automatic issue(input logic [3:0] av, input logic [3:0] bv, input logic cv, input bit hold);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_in_ready", in_ready, 0);
  endtask

  // Wait out the remaining latency and check the result as it appears.
  task automatic expect_result(input string tag, input logic [3:0] es, input logic ec);
    repeat (WIDTH - 1) @(posedge clk);
    #1 chk({tag, "_early_valid"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
  endtask

  task automatic handshake(input string tag, input logic [3:0] es, input logic ec);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_sum_kept"}, sum, es);
    chk({tag, "_cout_kept"}, cout, ec);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk) rst_n = 1'b1;

    issue(4'd14, 4'd5, 1'b0, 0);
    expect_result("add14_5", 4'd3, 1'b1);
    handshake("add14_5", 4'd3, 1'b1);

    issue(4'd5, 4'd8, 1'b1, 0);
    expect_result("sub5_7", 4'd14, 1'b0);
    handshake("sub5_7", 4'd14, 1'b0);

    issue(4'd8, 4'd7, 1'b1, 0);
    expect_result("sub8_8", 4'd0, 1'b1);
    handshake("sub8_8", 4'd0, 1'b1);

    issue(4'd15, 4'd15, 1'b1, 0);
    expect_result("max", 4'd15, 1'b1);
    handshake("max", 4'd15, 1'b1);

    issue(4'd0, 4'd0, 1'b0, 0);
    expect_result("zero", 4'd0, 1'b0);
    handshake("zero", 4'd0, 1'b0);

    // Backpressure: result must hold for 5 stalled cycles.
    issue(4'd9, 4'd4, 1'b0, 0);
    expect_result("bp", 4'd13, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 13);
      chk("bp_hold_cout", cout, 0);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    handshake("bp", 4'd13, 1'b0);

    // in_valid held with changing operands while busy.
    issue(4'd2, 4'd3, 1'b0, 1);
    @(negedge clk);
    a = 4'd9; b = 4'd1; cin = 1'b0;
    expect_result("hold1", 4'd5, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_no_same_cycle_accept", busy, 0);
    chk("hold_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold2_accepted", busy, 1);
    expect_result("hold2", 4'd10, 1'b0);
    handshake("hold2", 4'd10, 1'b0);

    // Reset at cycle 2 of SHIFT.
    issue(4'd14, 4'd5, 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (WIDTH + 1) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", out_valid, 0);
    end
    issue(4'd3, 4'd4, 1'b0, 0);
    expect_result("after_rst", 4'd7, 1'b0);
    handshake("after_rst", 4'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
